pipelined_adder_sub: RTL and testbench

- Parametrised, pipelined successor to the 32-bit ripple adder in the ALU datapath.
- Performs add or subtract of two WIDTH-bit operands.
- Splits the carry chain into STAGES registered chunks so the critical path is WIDTH/STAGES bits.
- Uses a valid/ready handshake and reports signed overflow and zero flags alongside carry-out.

---
 rtl/pipelined_adder_sub.sv | 117 +++++++++++
 tb/tb_pipelined_adder_sub.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_sub.sv
// Pipelined WIDTH-bit add/subtract with valid/ready flow control.
// The carry chain is cut into STAGES chunks of WIDTH/STAGES bits (WIDTH % STAGES must be 0).
module pipelined_adder_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  localparam int CW = WIDTH / STAGES;

  logic              stall;
  logic              advance;
  logic [STAGES-1:0] vld_q;
  logic [STAGES:0]   vld_chain;
  logic              v_q;

  // vld_chain[k] is the valid bit presented to stage k; the top bit is the output beat.
  assign vld_chain = {vld_q, in_valid};
  assign out_valid = vld_chain[STAGES];
  assign stall     = out_valid && !out_ready;
  assign advance   = !stall;
  assign in_ready  = advance;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (advance) begin
      vld_q <= vld_chain[STAGES-1:0];
    end
  end

  // Each stage carries one word: low chunks already summed, high chunks still X.
  // The conditioned Ye operand shrinks by one chunk per stage as it is consumed.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int YW = WIDTH - k * CW;

    logic [WIDTH-1:0] w_i;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_q;
    logic [YW-1:0]    y_i;
    logic             c_i;
    logic             c_q;
    logic [CW:0]      sum;

    if (k == 0) begin : g_src
      assign w_i = X;
      assign y_i = sub ? ~Y : Y;
      assign c_i = sub ? ~Cin : Cin;
    end else begin : g_src
      assign w_i = g_stage[k-1].w_q;
      assign y_i = g_stage[k-1].g_mid.y_q;
      assign c_i = g_stage[k-1].c_q;
    end

    assign sum = {1'b0, w_i[k*CW +: CW]} + {1'b0, y_i[CW-1:0]} + (CW + 1)'(c_i);

    // NOTE: the full default is assigned before the partial overwrite, so no latch is inferred.
    always_comb begin
      w_d              = w_i;
      w_d[k*CW +: CW]  = sum[CW-1:0];
    end

    if (k < STAGES - 1) begin : g_mid
      logic [YW-CW-1:0] y_q;

      // NOTE: datapath registers have no reset; the valid bits alone decide what is live.
      always_ff @(posedge clk) begin
        if (advance) begin
          w_q <= w_d;
          y_q <= y_i[YW-1:CW];
          c_q <= sum[CW];
        end
      end
    end else begin : g_last
      logic v_d;

      // Signed overflow: same-sign operands producing a result of the other sign.
      assign v_d = (w_i[WIDTH-1] == y_i[CW-1]) && (sum[CW-1] != w_i[WIDTH-1]);

      // Output registers only load real beats, so they stay quiet behind bubbles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          w_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (advance && vld_chain[k]) begin
          w_q <= w_d;
          c_q <= sum[CW];
          v_q <= v_d;
        end
      end

      assign S    = w_q;
      assign Cout = c_q;
    end
  end

  assign V = v_q;
  // Gated by out_valid so the flag reads 0 while the output register is idle or in reset.
  assign Z = out_valid && (S == '0);

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Scoreboard bench for pipelined_adder_sub: 32/4, 32/1 and 8/2 configurations side by side.
module tb_pipelined_adder_sub;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
    int          cyc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] xa [3];
  logic [31:0] ya [3];
  logic        cina [3];
  logic        suba [3];
  logic        iva [3];
  logic        ora [3];
  logic        ira [3];
  logic        ova [3];
  logic        couta [3];
  logic        va [3];
  logic        za [3];
  logic [31:0] s32a;
  logic [31:0] s32b;
  logic [7:0]  s8;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder_sub #(.WIDTH(32), .STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iva[0]), .in_ready(ira[0]),
    .X(xa[0]), .Y(ya[0]), .Cin(cina[0]), .sub(suba[0]),
    .out_valid(ova[0]), .out_ready(ora[0]), .S(s32a), .Cout(couta[0]), .V(va[0]), .Z(za[0]));

  pipelined_adder_sub #(.WIDTH(32), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iva[1]), .in_ready(ira[1]),
    .X(xa[1]), .Y(ya[1]), .Cin(cina[1]), .sub(suba[1]),
    .out_valid(ova[1]), .out_ready(ora[1]), .S(s32b), .Cout(couta[1]), .V(va[1]), .Z(za[1]));

  pipelined_adder_sub #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iva[2]), .in_ready(ira[2]),
    .X(xa[2][7:0]), .Y(ya[2][7:0]), .Cin(cina[2]), .sub(suba[2]),
    .out_valid(ova[2]), .out_ready(ora[2]), .S(s8), .Cout(couta[2]), .V(va[2]), .Z(za[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int lat_of(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t mk(input logic [31:0] s, input logic c, input logic v, input logic z);
    exp_t e;
    e.s = s; e.c = c; e.v = v; e.z = z; e.cyc = 0; e.lat = 1'b1;
    return e;
  endfunction

  // Reference by plain integer arithmetic: unsigned for S/Cout, signed range test for V.
  function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                 input logic cin, input logic sb, input bit lat);
    exp_t    e;
    longint  m, half, ux, uy, sx, sy, ci, ru, rs;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ux   = longint'(x) & m;
    uy   = longint'(y) & m;
    sx   = (ux >= half) ? ux - 2 * half : ux;
    sy   = (uy >= half) ? uy - 2 * half : uy;
    ci   = longint'(cin);
    if (sb) begin
      ru  = ux - uy - ci;
      rs  = sx - sy - ci;
      e.c = (ux >= uy + ci);
    end else begin
      ru  = ux + uy + ci;
      rs  = sx + sy + ci;
      e.c = (ru > m);
    end
    e.s   = 32'(ru & m);
    e.v   = (rs >= half) || (rs < -half);
    e.z   = (e.s == 32'd0);
    e.cyc = 0;
    e.lat = lat;
    return e;
  endfunction

  task automatic pop_check(input int d, input logic [31:0] obs_s);
    exp_t e;
    int   qs;
    qs = qsize(d);
    check($sformatf("beat_expected_dut%0d", d), 32'(qs != 0), 32'd1);
    if (qs == 0) return;
    case (d)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    check($sformatf("S_dut%0d", d), obs_s, e.s);
    check($sformatf("Cout_dut%0d", d), 32'(couta[d]), 32'(e.c));
    check($sformatf("V_dut%0d", d), 32'(va[d]), 32'(e.v));
    check($sformatf("Z_dut%0d", d), 32'(za[d]), 32'(e.z));
    if (e.lat) check($sformatf("latency_dut%0d", d), 32'(cyc - e.cyc), 32'(lat_of(d)));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ova[0] && ora[0]) pop_check(0, s32a);
      if (ova[1] && ora[1]) pop_check(1, s32b);
      if (ova[2] && ora[2]) pop_check(2, {24'd0, s8});
    end
  end

  // Presents a beat, holds it until accepted, and records the expectation at acceptance.
  task automatic send(input int d, input logic [31:0] x, input logic [31:0] y,
                      input logic cin, input logic sb, input exp_t e);
    int n;
    xa[d] = x; ya[d] = y; cina[d] = cin; suba[d] = sb; iva[d] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ira[d] && n < 50) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("accept_dut%0d", d), 32'(ira[d]), 32'd1);
    if (ira[d]) begin
      e.cyc = cyc;
      case (d)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    @(posedge clk);
    #1;
    iva[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("drain_dut%0d", d), 32'(qsize(d)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rx, ry;
    logic        rc, rs;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      xa[i] = '0; ya[i] = '0; cina[i] = 1'b0; suba[i] = 1'b0; iva[i] = 1'b0; ora[i] = 1'b1;
    end
    #2;
    check("rst_out_valid", 32'(ova[0]), 32'd0);
    check("rst_in_ready", 32'(ira[0]), 32'd1);
    check("rst_S", s32a, 32'd0);
    check("rst_Cout", 32'(couta[0]), 32'd0);
    check("rst_V", 32'(va[0]), 32'd0);
    check("rst_Z", 32'(za[0]), 32'd0);
    check("rst_out_valid_dut8", 32'(ova[2]), 32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases, 32-bit / 4 stages.
    send(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1));
    drain(0);
    send(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0));
    send(0, 32'd5, 32'd7, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    send(0, 32'h8000_0000, 32'h1, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    send(0, 32'd10, 32'd3, 1'b1, 1'b1, mk(32'd6, 1'b1, 1'b0, 1'b0));
    drain(0);

    // Back-to-back random stream with the sink always ready.
    for (int i = 0; i < 8; i++) begin
      rx = $urandom; ry = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      send(0, rx, ry, rc, rs, model(32, rx, ry, rc, rs, 1'b1));
    end
    drain(0);

    // Sink stalls for 5 sampled cycles while the source keeps pushing.
    ora[0] = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          rx = $urandom; ry = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
          send(0, rx, ry, rc, rs, model(32, rx, ry, rc, rs, 1'b0));
        end
      end
      begin
        for (int n = 0; n < 20 && !ova[0]; n++) @(negedge clk);
        check("stall_out_valid", 32'(ova[0]), 32'd1);
        for (int n = 0; n < 5; n++) begin
          @(negedge clk);
          check("stall_in_ready", 32'(ira[0]), 32'd0);
          check("stall_out_valid_held", 32'(ova[0]), 32'd1);
          check("stall_S_frozen", s32a, q0[0].s);
          check("stall_Cout_frozen", 32'(couta[0]), 32'(q0[0].c));
          check("stall_V_frozen", 32'(va[0]), 32'(q0[0].v));
          check("stall_Z_frozen", 32'(za[0]), 32'(q0[0].z));
        end
        @(posedge clk);
        #1;
        ora[0] = 1'b1;
      end
    join
    drain(0);

    // Asynchronous reset with three beats in flight; nothing stale may emerge.
    for (int i = 0; i < 3; i++) begin
      rx = $urandom; ry = $urandom;
      send(0, rx, ry, 1'b0, 1'b0, model(32, rx, ry, 1'b0, 1'b0, 1'b1));
    end
    @(posedge clk);
    #2;
    check("pre_reset_out_valid", 32'(ova[0]), 32'd1);
    #1;
    rst_n = 1'b0;
    q0.delete();
    #1;
    check("async_rst_out_valid", 32'(ova[0]), 32'd0);
    check("async_rst_S", s32a, 32'd0);
    check("async_rst_V", 32'(va[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("no_stale_out_valid", 32'(ova[0]), 32'd0);
    @(posedge clk);
    #1;

    // Single registered ripple adder.
    send(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1));
    send(1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    send(1, 32'd5, 32'd7, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    send(1, 32'h8000_0000, 32'h1, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    send(1, 32'd10, 32'd3, 1'b1, 1'b1, mk(32'd6, 1'b1, 1'b0, 1'b0));
    drain(1);

    // 8-bit, two stages.
    send(2, 32'hFF, 32'h01, 1'b0, 1'b0, mk(32'h00, 1'b1, 1'b0, 1'b1));
    send(2, 32'h7F, 32'h01, 1'b0, 1'b0, mk(32'h80, 1'b0, 1'b1, 1'b0));
    send(2, 32'h80, 32'h01, 1'b0, 1'b1, mk(32'h7F, 1'b1, 1'b1, 1'b0));
    send(2, 32'h05, 32'h07, 1'b0, 1'b1, mk(32'hFE, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      rx = 32'($urandom_range(0, 255)); ry = 32'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      send(2, rx, ry, rc, rs, model(8, rx, ry, rc, rs, 1'b1));
    end
    drain(2);

    repeat (4) @(negedge clk);
    check("final_q0_empty", 32'(q0.size()), 32'd0);
    check("final_q1_empty", 32'(q1.size()), 32'd0);
    check("final_q2_empty", 32'(q2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
